// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package bit_serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Encodings are kept identical to the former ST_* localparams.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/one_bit_full_adder_structural.sv
// Gate-level one-bit full adder cell used as the serial datapath core.
module one_bit_full_adder_structural (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  logic ab_x;
  logic ab_a;
  logic c_a;

  assign ab_x = A ^ B;
  assign ab_a = A & B;
  assign c_a  = ab_x & Cin;
  assign S    = ab_x ^ Cin;
  assign Cout = ab_a | c_a;

endmodule

// File: rtl/bit_serial_adder.sv
// WIDTH-bit adder that processes one bit pair per clock, LSB first, through a
// single full adder cell; result presented with a one-cycle done pulse.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fa_s;
  logic fa_cout;

  one_bit_full_adder_structural u_fa (
    .A    (sha_q[0]),
    .B    (shb_q[0]),
    .Cin  (carry_q),
    .S    (fa_s),
    .Cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sha_d   = A;
          shb_d   = B;
          carry_d = Cin;
          cnt_d   = '0;
          s_d     = '0;
          cout_d  = 1'b0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // Sum bits enter at the MSB so S is LSB-aligned after WIDTH shifts.
        carry_d = fa_cout;
        s_d     = {fa_s, s_q[WIDTH-1:1]};
        sha_d   = sha_q >> 1;
        shb_d   = shb_q >> 1;
        if (cnt_q == LAST) begin
          cout_d  = fa_cout;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are decodes of the state register only.
  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign S    = s_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder (WIDTH=8): stimulus pushes expected
// {Cout,S}; a monitor pops and compares on every done pulse.
module tb_bit_serial_adder;

  localparam int unsigned W = 8;
  typedef logic [W:0] res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A, B, S;
  logic         Cin, busy, done, Cout;

  int   vectors     = 0;
  int   miscompares = 0;
  int   busy_cycles = 0;
  res_t exp_q[$];
  res_t mon_exp;

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Cout  (Cout)
  );

  task automatic check(input string name, input res_t act, input res_t req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      busy_cycles = 0;
    end else begin
      if (busy) busy_cycles++;
      if (done) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_done: got done=1 with no pending result, S=%h Cout=%b", S, Cout);
        end else begin
          mon_exp = exp_q.pop_front();
          check("sum", {Cout, S}, mon_exp);
          check("busy_len", res_t'(busy_cycles), res_t'(W));
        end
        busy_cycles = 0;
      end
    end
  end

  // Called at a falling edge with the DUT idle; returns one falling edge later.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input bit push, input res_t expv);
    start = 1'b1;
    A     = a;
    B     = b;
    Cin   = c;
    if (push) exp_q.push_back(expv);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done, then steps into the following idle cycle.
  task automatic wait_done();
    int n = 0;
    while (!done && n < 3 * W) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected a done pulse", 3 * W);
    end
    @(negedge clk);
  endtask

  task automatic add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                     input res_t expv);
    issue(a, b, c, 1'b1, expv);
    wait_done();
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;

    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    Cin   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", res_t'(busy), '0);
    check("reset_done", res_t'(done), '0);
    check("reset_sum",  {Cout, S},    '0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors with hand-computed results
    add(8'h0F, 8'h01, 1'b0, 9'h010);
    add(8'hFF, 8'h01, 1'b0, 9'h100);
    add(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    add(8'h00, 8'h00, 1'b0, 9'h000);

    // Second start during RUN cycle 3 must be ignored
    issue(8'h12, 8'h34, 1'b0, 1'b1, 9'h046);
    repeat (2) @(negedge clk);
    start = 1'b1;
    A     = 8'h77;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);

    // Reset during RUN cycle 4 aborts the addition with no done pulse
    issue(8'h55, 8'h0F, 1'b0, 1'b0, '0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", res_t'(busy), '0);
    check("abort_done", res_t'(done), '0);
    check("abort_sum",  {Cout, S},    '0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_idle_busy", res_t'(busy), '0);
    add(8'h55, 8'h0F, 1'b0, 9'h064);

    // LSB/carry-in sweep, back-to-back
    add(8'h00, 8'h00, 1'b0, 9'h000);
    add(8'h00, 8'h00, 1'b1, 9'h001);
    add(8'h00, 8'h01, 1'b0, 9'h001);
    add(8'h00, 8'h01, 1'b1, 9'h002);
    add(8'h01, 8'h00, 1'b0, 9'h001);
    add(8'h01, 8'h00, 1'b1, 9'h002);
    add(8'h01, 8'h01, 1'b0, 9'h002);
    add(8'h01, 8'h01, 1'b1, 9'h003);

    // Random vectors against an arithmetic reference
    for (int i = 0; i < 256; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      add(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + res_t'(rc));
    end

    repeat (5) @(negedge clk);
    check("pending_results", res_t'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
